sgr_sequence_parser: RTL
========================

# sgr_sequence_parser

Byte-level front end of the parser stage. It consumes the decoded terminal byte stream, recognises `ESC [ Pn ; … m` (SGR) control sequences, converts decimal parameters to 8-bit values, and issues single-cycle commands (`INIT_PN`, `EMIT_PN`, `SGR`, `SGR0`) to the graphics-attribute controller directly downstream. All other bytes outside a sequence pass through on a character port for the text writer.

## Interface
- `MAX_PN`, default 16: maximum number of parameters per sequence. Further parameters make the sequence discarded.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `inValid`  in  1  upstream byte valid.
- `inData`  in  8  upstream byte.
- `inReady`  out  1  byte accepted when `inValid && inReady` at a rising edge.
- `commandReady`  out  1  single-cycle command strobe.
- `commandType`  out  `CommandsType`  command code; holds its value between strobes.
- `Pns`  out  8  parameter value carried with the command.
- `charReady`  out  1  single-cycle pass-through strobe.
- `charData`  out  8  pass-through byte.

## Operation
- States: `S_IDLE`, `S_ESC`, `S_PARAM`, `S_IGNORE`.
- `S_IDLE`
  - `0x1B` → `S_ESC`.
  - Any other byte → `charReady` pulse with `charData` = byte.
- `S_ESC`
  - `[` (0x5B) → `S_PARAM`. Emit `INIT_PN` with `Pns=0`, clear the accumulator, clear the parameter count, clear `hasDigits`.
  - `0x1B` → stay in `S_ESC`.
  - Anything else → `S_IDLE`, no output.
- `S_PARAM`
  - Digit `0x30–0x39`: `acc = min(255, acc*10 + d)`. Compute in 12 bits. Saturation is sticky until the parameter is terminated. Set `hasDigits`.
  - `;` (0x3B): emit `EMIT_PN` with `Pns=acc` (an empty parameter gives 0). Increment the count, clear `acc`, set `hasDigits`.
  - `m` (0x6D):
    - If no digit and no `;` has been seen, emit `SGR0` with `Pns=0`.
    - Otherwise emit `SGR` with `Pns=acc`.
    - Go to `S_IDLE`.
  - If the count reaches `MAX_PN` on a `;` → `S_IGNORE`, no `EMIT_PN` for that parameter.
  - Private/intermediate bytes `0x20–0x2F` and `0x3C–0x3F` → `S_IGNORE`.
  - Other final bytes `0x40–0x7E` (except `m`) → `S_IDLE`, nothing emitted.
- `S_IGNORE`: consume bytes until a final byte `0x40–0x7E`, then → `S_IDLE`. Nothing is emitted.
- In any state other than `S_IDLE`:
  - CAN (0x18) or SUB (0x1A) → `S_IDLE`, silent.
  - `0x1B` → `S_ESC`.
- Any other control byte `<0x20` inside a sequence is passed through on `charReady` and does not change state.
- At most one strobe (command or char) per accepted byte. `commandReady` and `charReady` are never high together.

## Timing
- All outputs are registered. A byte accepted in cycle N produces its strobe in cycle N+1.
- `inReady = !(commandReady && commandType ∈ {SGR, SGR0})`, combinational from registers.
  - This guarantees no strobe in the cycle after an `SGR`/`SGR0` strobe, which is when the downstream controller commits its attribute set.
  - Otherwise `inReady` stays high, giving 1 byte per cycle.
- Reset state: `S_IDLE`, `acc=0`, count 0, `commandReady=0`, `charReady=0`, `commandType=SGR0`, `Pns=0`, `charData=0`.
  - `inReady` is 1 while `rst` is low.
- Reset mid-sequence drops the partial sequence immediately. Any strobe high at assertion clears asynchronously.
- `inValid` low leaves all state unchanged. Strobes still drop after one cycle.

## Structure
- Shared package `DataType.svh`:
  - Existing `CommandsType` (`INIT_PN`, `EMIT_PN`, `SGR`, `SGR0`).
  - New ASCII constants `ASCII_ESC`, `ASCII_LBRACKET`, `ASCII_SEMI`, `ASCII_M`, `ASCII_CAN`, `ASCII_SUB`.
  - New enum `SgrParserState_t`.
- One sub-module, `pn_accumulator`:
  - Clears on command and loads on digit.
  - Does the saturating ×10+digit arithmetic and outputs an 8-bit value.

## Test plan
- Bytes `1B 5B 33 31 3B 31 6D` back-to-back:
  - Strobes `INIT_PN/0`, then `EMIT_PN/31`, then `SGR/1`.
  - `inReady` is low exactly in the `SGR` strobe cycle.
  - No `charReady`.
- `1B 5B 6D` → `INIT_PN/0`, then `SGR0/0`. Then `41` → `charReady` with `charData=0x41` two cycles after the `SGR0` strobe.
- `1B 5B 33 38 3B 35 3B 32 30 38 6D` → `EMIT_PN/38`, `EMIT_PN/5`, `SGR/208`.
- `1B 5B 39 39 39 39 3B 3B 6D` → `EMIT_PN/255` (saturated), `EMIT_PN/0`, `SGR/0`.
- `1B 5B 3F 32 35 68` and `1B 5B 31 32 4A` → only `INIT_PN`, then back to `S_IDLE`. Next `42` passes through.
- `1B 5B 33 18 41` → `INIT_PN`, silent abort, `charReady/0x41`. Repeat with `rst` pulsed after `33`: outputs go to 0 asynchronously, then `41` passes through.

Source files
------------

// File: rtl/sgr_sequence_parser_pkg.sv
// Shared command, state and byte definitions for the SGR sequence parser.
package sgr_sequence_parser_pkg;

    typedef enum logic [1:0] {
        INIT_PN,
        EMIT_PN,
        SGR,
        SGR0
    } CommandsType;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ESC,
        S_PARAM,
        S_IGNORE
    } SgrParserState_t;

    localparam logic [7:0] ASCII_ESC      = 8'h1B;
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] ASCII_SEMI     = 8'h3B;
    localparam logic [7:0] ASCII_M        = 8'h6D;
    localparam logic [7:0] ASCII_CAN      = 8'h18;
    localparam logic [7:0] ASCII_SUB      = 8'h1A;

endpackage

// File: rtl/sgr_sequence_parser_if.sv
// Byte input and command/character output bundle of the SGR parser.
interface sgr_sequence_parser_if;
    import sgr_sequence_parser_pkg::*;

    logic        inValid;
    logic [7:0]  inData;
    logic        inReady;
    logic        commandReady;
    CommandsType commandType;
    logic [7:0]  Pns;
    logic        charReady;
    logic [7:0]  charData;

    modport master (
        output inValid, inData,
        input  inReady, commandReady, commandType, Pns,
        input  charReady, charData
    );

    modport slave (
        input  inValid, inData,
        output inReady, commandReady, commandType, Pns,
        output charReady, charData
    );

endinterface

// File: rtl/sgr_sequence_parser_pn_accumulator.sv
// Decimal parameter accumulator: acc = min(255, acc*10 + digit).
module pn_accumulator (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] digit_i,
    output logic [7:0] acc_o
);

    logic [7:0]  acc_q;
    logic [7:0]  acc_d;
    logic [11:0] sum;

    always_comb begin
        sum   = 12'(acc_q) * 12'd10 + 12'(digit_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = (sum > 12'd255) ? 8'hFF : sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sgr_sequence_parser.sv
// Recognises ESC [ Pn ; ... m and issues parameter/SGR commands;
// other bytes pass through on the character port.
module sgr_sequence_parser
    import sgr_sequence_parser_pkg::*;
#(
    parameter int MAX_PN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sgr_sequence_parser_if.slave sgr_if
);

    localparam int            CW      = $clog2(MAX_PN + 1);
    localparam logic [CW-1:0] LAST_PN = CW'(MAX_PN - 1);

    SgrParserState_t state_q;
    logic [CW-1:0]   count_q;
    logic            has_digits_q;
    logic            cmd_valid_q;
    CommandsType     cmd_type_q;
    logic [7:0]      pns_q;
    logic            char_valid_q;
    logic [7:0]      char_data_q;

    logic [7:0] b;
    logic [7:0] acc;
    logic       in_ready;
    logic       accept;
    logic       acc_clr;
    logic       acc_load;
    logic       is_ctl;
    logic       is_abort;
    logic       is_digit;
    logic       is_final;
    logic       is_inter;

    assign b        = sgr_if.inData;
    assign in_ready = !(cmd_valid_q &&
                        (cmd_type_q == SGR || cmd_type_q == SGR0));
    assign accept   = sgr_if.inValid && in_ready;

    assign is_ctl   = (b < 8'h20);
    assign is_abort = (b == ASCII_CAN) || (b == ASCII_SUB);
    assign is_digit = (b >= 8'h30) && (b <= 8'h39);
    assign is_final = (b >= 8'h40) && (b <= 8'h7E);
    // ':' sub-parameter separators are not supported, so they discard too
    assign is_inter = ((b >= 8'h20) && (b <= 8'h2F)) ||
                      ((b >= 8'h3A) && (b <= 8'h3F) && (b != ASCII_SEMI));

    always_comb begin
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        if (accept && !is_ctl) begin
            if (state_q == S_ESC) begin
                acc_clr = (b == ASCII_LBRACKET);
            end
            if (state_q == S_PARAM) begin
                acc_clr  = (b == ASCII_SEMI) || (b == ASCII_M);
                acc_load = is_digit;
            end
        end
    end

    pn_accumulator u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (acc_clr),
        .load_i  (acc_load),
        .digit_i (b[3:0]),
        .acc_o   (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            has_digits_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= SGR0;
            pns_q        <= '0;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
        end else begin
            cmd_valid_q  <= 1'b0;
            char_valid_q <= 1'b0;
            if (accept) begin
                if (state_q == S_IDLE) begin
                    if (b == ASCII_ESC) begin
                        state_q <= S_ESC;
                    end else begin
                        char_valid_q <= 1'b1;
                        char_data_q  <= b;
                    end
                end else if (is_abort) begin
                    state_q <= S_IDLE;
                end else if (b == ASCII_ESC) begin
                    state_q <= S_ESC;
                end else if (is_ctl) begin
                    char_valid_q <= 1'b1;
                    char_data_q  <= b;
                end else begin
                    case (state_q)
                        S_ESC: begin
                            if (b == ASCII_LBRACKET) begin
                                state_q      <= S_PARAM;
                                count_q      <= '0;
                                has_digits_q <= 1'b0;
                                cmd_valid_q  <= 1'b1;
                                cmd_type_q   <= INIT_PN;
                                pns_q        <= '0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                        S_PARAM: begin
                            if (is_digit) begin
                                has_digits_q <= 1'b1;
                            end else if (b == ASCII_SEMI) begin
                                has_digits_q <= 1'b1;
                                if (count_q == LAST_PN) begin
                                    state_q <= S_IGNORE;
                                end else begin
                                    count_q     <= count_q + CW'(1);
                                    cmd_valid_q <= 1'b1;
                                    cmd_type_q  <= EMIT_PN;
                                    pns_q       <= acc;
                                end
                            end else if (b == ASCII_M) begin
                                state_q     <= S_IDLE;
                                cmd_valid_q <= 1'b1;
                                cmd_type_q  <= has_digits_q ? SGR : SGR0;
                                pns_q       <= has_digits_q ? acc : 8'h00;
                            end else if (is_inter) begin
                                state_q <= S_IGNORE;
                            end else if (is_final) begin
                                state_q <= S_IDLE;
                            end
                        end
                        S_IGNORE: begin
                            if (is_final) begin
                                state_q <= S_IDLE;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign sgr_if.inReady      = in_ready;
    assign sgr_if.commandReady = cmd_valid_q;
    assign sgr_if.commandType  = cmd_type_q;
    assign sgr_if.Pns          = pns_q;
    assign sgr_if.charReady    = char_valid_q;
    assign sgr_if.charData     = char_data_q;

endmodule
